// File: rtl/count_capture_pkg.sv
// Shared types and constants for the count_capture block.
// entry_t is the record held per FIFO slot: sampled count, wrap flag and,
// with COUNT_CAPTURE_TIMESTAMP_EN defined, the capture-cycle timestamp.
package count_capture_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = 16;
  // Widest count the entry record can carry; WIDTH must not exceed this.
  localparam int MAX_WIDTH     = 64;
  localparam int TS_WIDTH      = 16;

  // Bits of data above the instance WIDTH are always written as zero.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
    logic                 wrap;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]  stamp;
`endif
  } entry_t;

endpackage

// File: rtl/count_capture_if.sv
// Output handshake bundle of count_capture: head entry fields plus valid/ready.
// Ports: out_data, out_wrap, out_valid (producer->consumer), out_ready (consumer->producer),
//        out_time (producer->consumer, only with COUNT_CAPTURE_TIMESTAMP_EN).
interface count_capture_if
  import count_capture_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0]    out_data;
  logic                out_wrap;
  logic                out_valid;
  logic                out_ready;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] out_time;
`endif

`ifdef COUNT_CAPTURE_TIMESTAMP_EN
  modport master (output out_data, out_wrap, out_valid, out_time, input out_ready);
  modport slave  (input out_data, out_wrap, out_valid, out_time, output out_ready);
`else
  modport master (output out_data, out_wrap, out_valid, input out_ready);
  modport slave  (input out_data, out_wrap, out_valid, output out_ready);
`endif

endinterface

// File: rtl/count_capture_fifo.sv
// Entry storage for count_capture: DEPTH-slot circular FIFO with flush, full/empty and level.
// Ports: clock, reset (async active-low), flush, push/push_entry, pop, head_entry, full, empty, level.
// Push while full is accepted only with a simultaneous pop; pop while empty is ignored.
module count_capture_fifo
  import count_capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  output entry_t                   head_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic            push_ok;
  logic            pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A slot frees up on the same edge when popping, so full does not block.
  assign push_ok = push && (!full || pop_ok);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(push_ok) - LW'(pop_ok);
    end
  end

  // Slot contents need no reset: a slot is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head_entry = mem[rd_ptr];
  assign level      = count;

endmodule

// File: rtl/count_capture.sv
// Captures each change of an upstream modulo counter into a FIFO, tagging wraps (new < previous).
// Ports: clock, reset (async active-low), count_in, clear, cap (count_capture_if.master), overflow, level.
// Optional macro COUNT_CAPTURE_TIMESTAMP_EN adds a 16-bit cycle stamp per entry and cap.out_time.
module count_capture
  import count_capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       count_in,
  input  logic                   clear,
  count_capture_if.master        cap,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  logic [WIDTH-1:0] prev;
  entry_t           push_entry;
  entry_t           head_entry;
  logic             capture;
  logic             pop;
  logic             full;
  logic             empty;

`ifdef COUNT_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] cycle;

  // Free-running; an entry stores the value present during its capture cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle <= '0;
    else        cycle <= cycle + TS_WIDTH'(1);
  end
`endif

  // clear wins over everything on its edge: no capture, no pop.
  assign capture = (count_in != prev) && !clear;
  assign pop     = cap.out_valid && cap.out_ready && !clear;

  always_comb begin
    push_entry                  = '0;
    push_entry.data[WIDTH-1:0]  = count_in;
    push_entry.wrap             = (count_in < prev);
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
    push_entry.stamp            = cycle;
`endif
  end

  // prev tracks count_in every edge, including clear edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev <= '0;
    else        prev <= count_in;
  end

  // A capture is dropped only when the FIFO is full and no pop makes room.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        overflow <= 1'b0;
    else if (clear)                    overflow <= 1'b0;
    else if (capture && full && !pop)  overflow <= 1'b1;
  end

  count_capture_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (clear),
    .push       (capture),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .full       (full),
    .empty      (empty),
    .level      (level)
  );

  // Head fields are forced to zero while empty so stale slot data never leaks.
  assign cap.out_valid = !empty;
  assign cap.out_data  = empty ? '0   : head_entry.data[WIDTH-1:0];
  assign cap.out_wrap  = empty ? 1'b0 : head_entry.wrap;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
  assign cap.out_time  = empty ? '0   : head_entry.stamp;
`endif

endmodule

// File: tb/tb_count_capture.sv
module tb_count_capture;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] count_in;
  logic             clear;
  logic             overflow;
  logic [2:0]       level;

  count_capture_if #(.WIDTH(WIDTH)) cap ();

  count_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .count_in (count_in),
    .clear    (clear),
    .cap      (cap),
    .overflow (overflow),
    .level    (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of {data, wrap}, previous sample, sticky overflow.
  logic [16:0] mq [$];
  logic [15:0] m_prev;
  logic        m_ov;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
  logic [15:0] mt [$];
  int          m_cyc;
`endif

  function automatic void model_reset();
    mq.delete();
    m_prev = '0;
    m_ov   = 1'b0;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
    mt.delete();
    m_cyc = 0;
`endif
  endfunction

  function automatic void model_edge(input logic [15:0] cin, input logic clr, input logic rdy);
    bit do_pop;
    if (clr) begin
      mq.delete();
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
      mt.delete();
`endif
      m_ov = 1'b0;
    end else begin
      do_pop = (mq.size() > 0) && rdy;
      if (do_pop) begin
        void'(mq.pop_front());
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
        void'(mt.pop_front());
`endif
      end
      if (cin != m_prev) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({cin, (cin < m_prev)});
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
          mt.push_back(16'(m_cyc));
`endif
        end else begin
          m_ov = 1'b1;
        end
      end
    end
    m_prev = cin;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
    m_cyc = (m_cyc + 1) % 65536;
`endif
  endfunction

  // {valid, data, wrap, level, overflow}
  function automatic logic [21:0] exp_vec();
    logic [16:0] h;
    h = (mq.size() > 0) ? mq[0] : 17'd0;
    return {(mq.size() > 0), h, 3'(mq.size()), m_ov};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {cap.out_valid, cap.out_data, cap.out_wrap, level, overflow};
  endfunction

  task automatic step(input logic [15:0] cin, input logic clr, input logic rdy);
    @(negedge clock);
    count_in      = cin;
    clear         = clr;
    cap.out_ready = rdy;
    @(posedge clock);
    model_edge(cin, clr, rdy);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; count_in = 16'd0; clear = 1'b0; cap.out_ready = 1'b0;
    model_reset();
    #22;
    checks++;
    if (dut_vec() !== 22'd0) begin
      failures++; $display("FAIL reset_state got=%h want=%h", dut_vec(), 22'd0);
    end
    @(negedge clock); reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(16'd0, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== 22'd0) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, dut_vec(), 22'd0);
      end
    end
  endtask

  task automatic test_sequence();
    logic [21:0] want;
    for (int i = 1; i <= 8; i++) begin
      step(16'(i % 8), 1'b0, 1'b1);
      want = {1'b1, 16'(i % 8), (i == 8), 3'd1, 1'b0};
      checks++;
      if (dut_vec() !== want) begin
        failures++; $display("FAIL seq_mod8 i=%0d got=%h want=%h", i, dut_vec(), want);
      end
    end
    step(16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    logic [21:0] want;
    step(16'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) step(16'(i), 1'b0, 1'b0);
    want = {1'b1, 16'd1, 1'b0, 3'd4, 1'b1};
    checks++;
    if (dut_vec() !== want) begin
      failures++; $display("FAIL ovf_full got=%h want=%h", dut_vec(), want);
    end
    for (int k = 1; k <= 4; k++) begin
      want = {1'b1, 16'(k), 1'b0, 3'(5 - k), 1'b1};
      checks++;
      if (dut_vec() !== want) begin
        failures++; $display("FAIL ovf_drain k=%0d got=%h want=%h", k, dut_vec(), want);
      end
      step(16'd6, 1'b0, 1'b1);
    end
    want = {1'b0, 16'd0, 1'b0, 3'd0, 1'b1};
    checks++;
    if (dut_vec() !== want) begin
      failures++; $display("FAIL ovf_empty got=%h want=%h", dut_vec(), want);
    end
  endtask

  task automatic test_full_push_pop();
    logic [21:0] want;
    step(16'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) step(16'(i), 1'b0, 1'b0);
    step(16'd5, 1'b0, 1'b1);
    want = {1'b1, 16'd2, 1'b0, 3'd4, 1'b0};
    checks++;
    if (dut_vec() !== want) begin
      failures++; $display("FAIL full_pushpop got=%h want=%h", dut_vec(), want);
    end
    for (int k = 3; k <= 5; k++) begin
      step(16'd5, 1'b0, 1'b1);
      checks++;
      if (cap.out_data !== 16'(k) || dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL full_order k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clear();
    logic [21:0] want;
    step(16'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) step(16'(i), 1'b0, 1'b0);
    checks++;
    if (level !== 3'd3) begin
      failures++; $display("FAIL clear_pre level got=%0d want=3", level);
    end
    step(16'd9, 1'b1, 1'b1);
    checks++;
    if (dut_vec() !== 22'd0) begin
      failures++; $display("FAIL clear_flush got=%h want=%h", dut_vec(), 22'd0);
    end
    step(16'd10, 1'b0, 1'b0);
    want = {1'b1, 16'd10, 1'b0, 3'd1, 1'b0};
    checks++;
    if (dut_vec() !== want) begin
      failures++; $display("FAIL clear_next got=%h want=%h", dut_vec(), want);
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] want;
    for (int i = 11; i <= 13; i++) step(16'(i), 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0; count_in = 16'd5; clear = 1'b0; cap.out_ready = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 22'd0) begin
      failures++; $display("FAIL reset_mid got=%h want=%h", dut_vec(), 22'd0);
    end
    @(negedge clock); reset = 1'b1;
    step(16'd5, 1'b0, 1'b0);
    want = {1'b1, 16'd5, 1'b0, 3'd1, 1'b0};
    checks++;
    if (dut_vec() !== want) begin
      failures++; $display("FAIL reset_first got=%h want=%h", dut_vec(), want);
    end
  endtask

  task automatic test_random();
    logic [15:0] cin;
    logic        clr;
    logic        rdy;
    for (int i = 0; i < 400; i++) begin
      cin = 16'($urandom_range(0, 5));
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 19) == 0);
      step(cin, clr, rdy);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

`ifdef COUNT_CAPTURE_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [15:0] cin;
    @(negedge clock);
    reset = 1'b0; count_in = 16'd0; clear = 1'b0; cap.out_ready = 1'b0;
    model_reset();
    @(negedge clock); reset = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      cin = (k < 3) ? 16'd0 : ((k < 10) ? 16'd1 : 16'd2);
      step(cin, 1'b0, (k >= 4));
      if (k == 3 || k == 10) begin
        checks++;
        if (cap.out_time !== 16'(k) || mt.size() == 0 || cap.out_time !== mt[0]) begin
          failures++; $display("FAIL timestamp k=%0d got=%0d want=%0d", k, cap.out_time, k);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_overflow();
    test_full_push_pop();
    test_clear();
    test_reset_mid();
    test_random();
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_capture.md
COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter DEPTH, 4, FIFO entries; power of two, 2..64.
REQ-002 Parameter WIDTH, 16, width of sampled count.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 count_in  input  WIDTH  count value from upstream modulo counter, sampled every rising edge.
REQ-006 clear  input  1  synchronous flush of FIFO and overflow flag.
REQ-007 out_data  output  WIDTH  count value of head entry.
REQ-008 out_wrap  output  1  head entry was captured on a wrap (new value < previous value).
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_ready  input  1  consumer accepts head entry.
REQ-011 overflow  output  1  sticky; a capture was dropped because the FIFO was full.
REQ-012 level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 The block SHALL hold a register prev of WIDTH bits, updated to count_in on every rising edge.
REQ-014 A capture SHALL occur on an edge where count_in != prev and clear is low; entry = {count_in, wrap = (count_in < prev)}, unsigned compare.
REQ-015 A captured entry SHALL be visible on out_data/out_wrap with out_valid high immediately after the capturing edge (one-cycle latency from count_in change).
REQ-016 A pop SHALL occur on an edge where out_valid and out_ready are both high; out_data/out_wrap SHALL NOT change while out_valid is high and out_ready is low.
REQ-017 Entries SHALL leave in capture order.
REQ-018 Push and pop on the same edge SHALL both take effect, including when full (no drop, level unchanged) and when empty plus push (no pop).
REQ-019 Push while full without a simultaneous pop SHALL drop the new entry, leave FIFO contents unchanged and set overflow.
REQ-020 overflow SHALL stay high until clear or reset.
REQ-021 clear high SHALL on that edge empty the FIFO, lower overflow, load prev with count_in and suppress capture; a simultaneous pop is ignored.
REQ-022 level SHALL equal pushes minus pops since last clear/reset, range 0..DEPTH.
REQ-023 out_data and out_wrap SHALL read 0 when out_valid is low.

Reset
REQ-024 On reset low, asynchronously: prev = 0, FIFO empty, out_valid = 0, out_data = 0, out_wrap = 0, overflow = 0, level = 0.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries; the first edge after release compares count_in against prev = 0.

Configuration
REQ-026 Macro COUNT_CAPTURE_TIMESTAMP_EN SHALL, when defined, add a free-running 16-bit cycle counter (reset 0, wraps 65535 -> 0), store its value with each entry and add output out_time [15:0] carrying the head entry's timestamp (0 when empty).
REQ-027 Without COUNT_CAPTURE_TIMESTAMP_EN the cycle counter, stored timestamp field and out_time port SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package count_capture_pkg SHALL hold the entry typedef (data, wrap, optional time), the default DEPTH and WIDTH constants and the timestamp width constant.
REQ-029 Storage SHALL be a sub-module count_capture_fifo (synchronous push/pop, flush, full/empty, level); change/wrap detection and overflow live in count_capture.

Verification
REQ-030 Reset, count_in held 0 for 10 cycles -> out_valid 0, level 0, overflow 0.
REQ-031 count_in 0,1,2,...,7,0 (modulo 8), out_ready 1 -> entries 1..7 with wrap 0, then 0 with wrap 1, each one cycle after its change.
REQ-032 DEPTH 4, out_ready 0, count_in 1..6 -> level 4, head 1, overflow 1; after out_ready 1 drains 1,2,3,4, then out_valid 0.
REQ-033 Full FIFO, count change with out_ready 1 on same edge -> level stays 4, no drop, overflow stays 0.
REQ-034 Three entries queued, clear pulse while count_in changes -> level 0, overflow 0, no capture; next change captured normally.
REQ-035 With COUNT_CAPTURE_TIMESTAMP_EN, changes at cycles 3 and 10 after reset release -> out_time 3 then 10.
